// File: rtl/decode_pkg.sv
// Shared decode constants: opcode encodings, field widths and one-hot bit positions
// for the opcode class, ALU op, branch condition and load/store size vectors.
package decode_pkg;

   localparam int OP_SIZE  = 12;
   localparam int ALU_SIZE = 28;
   localparam int GPR_SIZE = 5;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // Opcode class one-hot, lui in the MSB down to system in the LSB
   localparam int OPI_LUI      = 11;
   localparam int OPI_AUIPC    = 10;
   localparam int OPI_JAL      = 9;
   localparam int OPI_JALR     = 8;
   localparam int OPI_ALU_REG  = 7;
   localparam int OPI_ALU_REGW = 6;
   localparam int OPI_ALU_IMM  = 5;
   localparam int OPI_ALU_IMMW = 4;
   localparam int OPI_LOAD     = 3;
   localparam int OPI_STORE    = 2;
   localparam int OPI_BRANCH   = 1;
   localparam int OPI_SYSTEM   = 0;

   localparam int AI_ADD    = 0;
   localparam int AI_SLL    = 1;
   localparam int AI_SLT    = 2;
   localparam int AI_SLTU   = 3;
   localparam int AI_XOR    = 4;
   localparam int AI_SRL    = 5;
   localparam int AI_OR     = 6;
   localparam int AI_AND    = 7;
   localparam int AI_SUB    = 8;
   localparam int AI_SRA    = 9;
   localparam int AI_ADDW   = 10;
   localparam int AI_SLLW   = 11;
   localparam int AI_SRLW   = 12;
   localparam int AI_SUBW   = 13;
   localparam int AI_SRAW   = 14;
   localparam int AI_MUL    = 15;
   localparam int AI_MULH   = 16;
   localparam int AI_MULHSU = 17;
   localparam int AI_MULHU  = 18;
   localparam int AI_DIV    = 19;
   localparam int AI_DIVU   = 20;
   localparam int AI_REM    = 21;
   localparam int AI_REMU   = 22;
   localparam int AI_MULW   = 23;
   localparam int AI_DIVW   = 24;
   localparam int AI_DIVUW  = 25;
   localparam int AI_REMW   = 26;
   localparam int AI_REMUW  = 27;

   localparam int BR_BEQ  = 5;
   localparam int BR_BNE  = 4;
   localparam int BR_BLT  = 3;
   localparam int BR_BGE  = 2;
   localparam int BR_BLTU = 1;
   localparam int BR_BGEU = 0;

   localparam int LS_LB  = 10;
   localparam int LS_LH  = 9;
   localparam int LS_LW  = 8;
   localparam int LS_LD  = 7;
   localparam int LS_LBU = 6;
   localparam int LS_LHU = 5;
   localparam int LS_LWU = 4;
   localparam int LS_SB  = 3;
   localparam int LS_SH  = 2;
   localparam int LS_SW  = 1;
   localparam int LS_SD  = 0;

endpackage

// File: rtl/decode_fwd_mux.sv
// Operand forwarding select for one source register: the lowest-index matching
// producer wins, and a winner whose result is still pending raises a hazard.
module decode_fwd_mux
   import decode_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int NUM_FWD = 3,
   parameter int IDX_W   = GPR_SIZE
) (
   input  logic                     use_i,
   input  logic [IDX_W-1:0]         idx_i,
   input  logic [WIDTH-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]       fwd_valid_i,
   input  logic [NUM_FWD-1:0]       fwd_pending_i,
   input  logic [NUM_FWD*IDX_W-1:0] fwd_rd_i,
   input  logic [NUM_FWD*WIDTH-1:0] fwd_data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     hazard_o
);

   logic [NUM_FWD-1:0] match;
   logic [WIDTH-1:0]   src_data [NUM_FWD];
   logic               sel_pending;

   for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_src
      assign match[gi]    = fwd_valid_i[gi] && (fwd_rd_i[gi*IDX_W +: IDX_W] == idx_i)
                            && (idx_i != '0);
      assign src_data[gi] = fwd_data_i[gi*WIDTH +: WIDTH];
   end

   // Walk from oldest to youngest so the youngest match is the last one written
   always_comb begin
      data_o      = (idx_i == '0) ? '0 : rf_data_i;
      sel_pending = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (match[i]) begin
            data_o      = src_data[i];
            sel_pending = fwd_pending_i[i];
         end
      end
   end

   assign hazard_o = use_i & sel_pending;

endmodule

// File: rtl/decode_stage.sv
// RV64 decode stage with registered D->E outputs, operand forwarding and RAW stall.
// Define DECODE_RV64M_EN to decode the M-extension multiply/divide ops.
module decode_stage
   import decode_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int NUM_FWD  = 3,
   parameter int OP_SIZE  = 12,
   parameter int ALU_SIZE = 28,
   parameter int GPR_SIZE = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [31:0]                 in_instr,
   input  logic [WIDTH-1:0]            in_pc,
   input  logic                        flush,
   output logic [GPR_SIZE-1:0]         rf_rs1,
   output logic [GPR_SIZE-1:0]         rf_rs2,
   input  logic [WIDTH-1:0]            rf_rdata1,
   input  logic [WIDTH-1:0]            rf_rdata2,
   input  logic [NUM_FWD-1:0]          fwd_valid,
   input  logic [NUM_FWD-1:0]          fwd_pending,
   input  logic [NUM_FWD*GPR_SIZE-1:0] fwd_rd,
   input  logic [NUM_FWD*WIDTH-1:0]    fwd_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_pc,
   output logic [OP_SIZE-1:0]          out_opcode_info,
   output logic [ALU_SIZE-1:0]         out_alu_info,
   output logic [5:0]                  out_branch_info,
   output logic [10:0]                 out_ls_info,
   output logic [WIDTH-1:0]            out_imm,
   output logic [WIDTH-1:0]            out_rs1_data,
   output logic [WIDTH-1:0]            out_rs2_data,
   output logic [GPR_SIZE-1:0]         out_rs1,
   output logic [GPR_SIZE-1:0]         out_rs2,
   output logic [GPR_SIZE-1:0]         out_rd,
   output logic                        out_reg_wen,
   output logic                        out_illegal
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       use1, use2, haz1, haz2, hazard, capture;

   logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, rs1_data, rs2_data;

   logic [OP_SIZE-1:0]  opc_d;
   logic [ALU_SIZE-1:0] alu_d;
   logic [5:0]          br_d;
   logic [10:0]         ls_d;
   logic [WIDTH-1:0]    imm_d;
   logic                wen_d, ill_d;

   logic                valid_q, wen_q, ill_q;
   logic [WIDTH-1:0]    pc_q, imm_q, rs1_data_q, rs2_data_q;
   logic [OP_SIZE-1:0]  opc_q;
   logic [ALU_SIZE-1:0] alu_q;
   logic [5:0]          br_q;
   logic [10:0]         ls_q;
   logic [GPR_SIZE-1:0] rs1_q, rs2_q, rd_q;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];
   assign rf_rs1 = in_instr[19:15];
   assign rf_rs2 = in_instr[24:20];

   assign imm_i = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{(WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{(WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign imm_j = {{(WIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
   assign imm_u = {{(WIDTH-32){in_instr[31]}}, in_instr[31:12], 12'b0};

   always_comb begin
      opc_d = '0;
      alu_d = '0;
      br_d  = '0;
      ls_d  = '0;
      imm_d = '0;
      wen_d = 1'b0;
      ill_d = 1'b0;
      use1  = 1'b0;
      use2  = 1'b0;
      case (opcode)
         OPC_LUI:   begin opc_d[OPI_LUI] = 1'b1;   imm_d = imm_u; wen_d = 1'b1; end
         OPC_AUIPC: begin opc_d[OPI_AUIPC] = 1'b1; imm_d = imm_u; wen_d = 1'b1; end
         OPC_JAL:   begin opc_d[OPI_JAL] = 1'b1;   imm_d = imm_j; wen_d = 1'b1; end
         OPC_JALR: begin
            opc_d[OPI_JALR] = 1'b1; imm_d = imm_i; use1 = 1'b1; wen_d = 1'b1;
            ill_d = (f3 != 3'b000);
         end
         OPC_OP: begin
            opc_d[OPI_ALU_REG] = 1'b1; use1 = 1'b1; use2 = 1'b1; wen_d = 1'b1;
            case (f7)
               F7_BASE: begin
                  case (f3)
                     3'd0: alu_d[AI_ADD]  = 1'b1;
                     3'd1: alu_d[AI_SLL]  = 1'b1;
                     3'd2: alu_d[AI_SLT]  = 1'b1;
                     3'd3: alu_d[AI_SLTU] = 1'b1;
                     3'd4: alu_d[AI_XOR]  = 1'b1;
                     3'd5: alu_d[AI_SRL]  = 1'b1;
                     3'd6: alu_d[AI_OR]   = 1'b1;
                     default: alu_d[AI_AND] = 1'b1;
                  endcase
               end
               F7_ALT: begin
                  if (f3 == 3'd0)      alu_d[AI_SUB] = 1'b1;
                  else if (f3 == 3'd5) alu_d[AI_SRA] = 1'b1;
                  else                 ill_d = 1'b1;
               end
               F7_MULDIV: begin
`ifdef DECODE_RV64M_EN
                  case (f3)
                     3'd0: alu_d[AI_MUL]    = 1'b1;
                     3'd1: alu_d[AI_MULH]   = 1'b1;
                     3'd2: alu_d[AI_MULHSU] = 1'b1;
                     3'd3: alu_d[AI_MULHU]  = 1'b1;
                     3'd4: alu_d[AI_DIV]    = 1'b1;
                     3'd5: alu_d[AI_DIVU]   = 1'b1;
                     3'd6: alu_d[AI_REM]    = 1'b1;
                     default: alu_d[AI_REMU] = 1'b1;
                  endcase
`else
                  ill_d = 1'b1;
`endif
               end
               default: ill_d = 1'b1;
            endcase
         end
         OPC_OP32: begin
            opc_d[OPI_ALU_REGW] = 1'b1; use1 = 1'b1; use2 = 1'b1; wen_d = 1'b1;
            case ({f7, f3})
               {F7_BASE, 3'd0}: alu_d[AI_ADDW] = 1'b1;
               {F7_BASE, 3'd1}: alu_d[AI_SLLW] = 1'b1;
               {F7_BASE, 3'd5}: alu_d[AI_SRLW] = 1'b1;
               {F7_ALT, 3'd0}:  alu_d[AI_SUBW] = 1'b1;
               {F7_ALT, 3'd5}:  alu_d[AI_SRAW] = 1'b1;
`ifdef DECODE_RV64M_EN
               {F7_MULDIV, 3'd0}: alu_d[AI_MULW]  = 1'b1;
               {F7_MULDIV, 3'd4}: alu_d[AI_DIVW]  = 1'b1;
               {F7_MULDIV, 3'd5}: alu_d[AI_DIVUW] = 1'b1;
               {F7_MULDIV, 3'd6}: alu_d[AI_REMW]  = 1'b1;
               {F7_MULDIV, 3'd7}: alu_d[AI_REMUW] = 1'b1;
`endif
               default: ill_d = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            opc_d[OPI_ALU_IMM] = 1'b1; imm_d = imm_i; use1 = 1'b1; wen_d = 1'b1;
            case (f3)
               3'd0: alu_d[AI_ADD]  = 1'b1;
               3'd2: alu_d[AI_SLT]  = 1'b1;
               3'd3: alu_d[AI_SLTU] = 1'b1;
               3'd4: alu_d[AI_XOR]  = 1'b1;
               3'd6: alu_d[AI_OR]   = 1'b1;
               3'd7: alu_d[AI_AND]  = 1'b1;
               3'd1: begin
                  if (in_instr[31:26] == 6'b000000) alu_d[AI_SLL] = 1'b1;
                  else                              ill_d = 1'b1;
               end
               default: begin
                  if (in_instr[31:26] == 6'b000000)      alu_d[AI_SRL] = 1'b1;
                  else if (in_instr[31:26] == 6'b010000) alu_d[AI_SRA] = 1'b1;
                  else                                   ill_d = 1'b1;
               end
            endcase
         end
         OPC_OPIMM32: begin
            opc_d[OPI_ALU_IMMW] = 1'b1; imm_d = imm_i; use1 = 1'b1; wen_d = 1'b1;
            if (f3 == 3'd0)                         alu_d[AI_ADDW] = 1'b1;
            else if (f3 == 3'd1 && f7 == F7_BASE)   alu_d[AI_SLLW] = 1'b1;
            else if (f3 == 3'd5 && f7 == F7_BASE)   alu_d[AI_SRLW] = 1'b1;
            else if (f3 == 3'd5 && f7 == F7_ALT)    alu_d[AI_SRAW] = 1'b1;
            else                                    ill_d = 1'b1;
         end
         OPC_LOAD: begin
            opc_d[OPI_LOAD] = 1'b1; imm_d = imm_i; use1 = 1'b1; wen_d = 1'b1;
            case (f3)
               3'd0: ls_d[LS_LB]  = 1'b1;
               3'd1: ls_d[LS_LH]  = 1'b1;
               3'd2: ls_d[LS_LW]  = 1'b1;
               3'd3: ls_d[LS_LD]  = 1'b1;
               3'd4: ls_d[LS_LBU] = 1'b1;
               3'd5: ls_d[LS_LHU] = 1'b1;
               3'd6: ls_d[LS_LWU] = 1'b1;
               default: ill_d = 1'b1;
            endcase
         end
         OPC_STORE: begin
            opc_d[OPI_STORE] = 1'b1; imm_d = imm_s; use1 = 1'b1; use2 = 1'b1;
            case (f3)
               3'd0: ls_d[LS_SB] = 1'b1;
               3'd1: ls_d[LS_SH] = 1'b1;
               3'd2: ls_d[LS_SW] = 1'b1;
               3'd3: ls_d[LS_SD] = 1'b1;
               default: ill_d = 1'b1;
            endcase
         end
         OPC_BRANCH: begin
            opc_d[OPI_BRANCH] = 1'b1; imm_d = imm_b; use1 = 1'b1; use2 = 1'b1;
            case (f3)
               3'd0: br_d[BR_BEQ]  = 1'b1;
               3'd1: br_d[BR_BNE]  = 1'b1;
               3'd4: br_d[BR_BLT]  = 1'b1;
               3'd5: br_d[BR_BGE]  = 1'b1;
               3'd6: br_d[BR_BLTU] = 1'b1;
               3'd7: br_d[BR_BGEU] = 1'b1;
               default: ill_d = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
            // ecall/ebreak (funct3 0) write nothing; CSR ops return the old CSR value in rd
            opc_d[OPI_SYSTEM] = 1'b1; imm_d = imm_i; use1 = 1'b1;
            wen_d = (f3 != 3'd0);
            ill_d = (f3 == 3'd4);
         end
         default: ill_d = 1'b1;
      endcase
      if (ill_d) begin
         alu_d = '0;
         br_d  = '0;
         ls_d  = '0;
         wen_d = 1'b0;
      end
   end

   decode_fwd_mux #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .IDX_W(GPR_SIZE)) u_fwd_rs1 (
      .use_i(use1), .idx_i(rf_rs1), .rf_data_i(rf_rdata1),
      .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
      .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
      .data_o(rs1_data), .hazard_o(haz1)
   );

   decode_fwd_mux #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .IDX_W(GPR_SIZE)) u_fwd_rs2 (
      .use_i(use2), .idx_i(rf_rs2), .rf_data_i(rf_rdata2),
      .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
      .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
      .data_o(rs2_data), .hazard_o(haz2)
   );

   assign hazard   = in_valid & (haz1 | haz2);
   assign in_ready = ~flush & ~hazard & (~valid_q | out_ready);
   assign capture  = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         opc_q      <= '0;
         alu_q      <= '0;
         br_q       <= '0;
         ls_q       <= '0;
         imm_q      <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         wen_q      <= 1'b0;
         ill_q      <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (capture) begin
         valid_q    <= 1'b1;
         pc_q       <= in_pc;
         opc_q      <= opc_d;
         alu_q      <= alu_d;
         br_q       <= br_d;
         ls_q       <= ls_d;
         imm_q      <= imm_d;
         rs1_data_q <= rs1_data;
         rs2_data_q <= rs2_data;
         rs1_q      <= rf_rs1;
         rs2_q      <= rf_rs2;
         rd_q       <= in_instr[11:7];
         wen_q      <= wen_d;
         ill_q      <= ill_d;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid       = valid_q;
   assign out_pc          = pc_q;
   assign out_opcode_info = opc_q;
   assign out_alu_info    = alu_q;
   assign out_branch_info = br_q;
   assign out_ls_info     = ls_q;
   assign out_imm         = imm_q;
   assign out_rs1_data    = rs1_data_q;
   assign out_rs2_data    = rs2_data_q;
   assign out_rs1         = rs1_q;
   assign out_rs2         = rs2_q;
   assign out_rd          = rd_q;
   assign out_reg_wen     = wen_q;
   assign out_illegal     = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected decodes are queued when offered and
// compared when the stage presents them; also covers stall, hold, flush and reset.
module tb_decode_stage;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0]  in_instr;
   logic [63:0]  in_pc, rf_rdata1, rf_rdata2;
   logic [4:0]   rf_rs1, rf_rs2;
   logic [2:0]   fwd_valid, fwd_pending;
   logic [14:0]  fwd_rd;
   logic [191:0] fwd_data;
   logic [63:0]  out_pc, out_imm, out_rs1_data, out_rs2_data;
   logic [11:0]  out_opcode_info;
   logic [27:0]  out_alu_info;
   logic [5:0]   out_branch_info;
   logic [10:0]  out_ls_info;
   logic [4:0]   out_rs1, out_rs2, out_rd;
   logic         out_reg_wen, out_illegal;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] pc;
      logic [11:0] opc;
      logic [27:0] alu;
      logic [5:0]  br;
      logic [10:0] ls;
      logic [63:0] imm;
      logic [63:0] r1d;
      logic [63:0] r2d;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   exp_t held;

   decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode_info(out_opcode_info), .out_alu_info(out_alu_info),
      .out_branch_info(out_branch_info), .out_ls_info(out_ls_info), .out_imm(out_imm),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_reg_wen(out_reg_wen), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string field, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] pc, input logic [11:0] opc,
                               input logic [27:0] alu, input logic [5:0] br,
                               input logic [10:0] ls, input logic [63:0] imm,
                               input logic [63:0] r1d, input logic [63:0] r2d,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic wen, input logic ill);
      exp_t e;
      e.pc = pc; e.opc = opc; e.alu = alu; e.br = br; e.ls = ls; e.imm = imm;
      e.r1d = r1d; e.r2d = r2d; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.wen = wen; e.ill = ill;
      return e;
   endfunction

   task automatic cmp_fields(input string tag, input exp_t e);
      chk(tag, "pc",      out_pc, e.pc);
      chk(tag, "opcode",  64'(out_opcode_info), 64'(e.opc));
      chk(tag, "alu",     64'(out_alu_info), 64'(e.alu));
      chk(tag, "branch",  64'(out_branch_info), 64'(e.br));
      chk(tag, "ls",      64'(out_ls_info), 64'(e.ls));
      chk(tag, "imm",     out_imm, e.imm);
      chk(tag, "rs1_data", out_rs1_data, e.r1d);
      chk(tag, "rs2_data", out_rs2_data, e.r2d);
      chk(tag, "rs1",     64'(out_rs1), 64'(e.rs1));
      chk(tag, "rs2",     64'(out_rs2), 64'(e.rs2));
      chk(tag, "rd",      64'(out_rd), 64'(e.rd));
      chk(tag, "reg_wen", 64'(out_reg_wen), 64'(e.wen));
      chk(tag, "illegal", 64'(out_illegal), 64'(e.ill));
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      chk(tag, "out_valid", 64'(out_valid), 64'd1);
      checks++;
      assert (sb.size() > 0) else begin
         failures++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp_fields(tag, e);
         held = e;
      end
      $display("txn %s pc=%0h valid=%0b illegal=%0b", tag, out_pc, out_valid, out_illegal);
   endtask

   // Offer one instruction that must be accepted this cycle and shown one edge later
   task automatic offer(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                        input exp_t e);
      in_instr = instr;
      in_pc    = pc;
      in_valid = 1'b1;
      #1;
      chk(tag, "in_ready", 64'(in_ready), 64'd1);
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_out(tag);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      exp_t e;
      in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
      rf_rdata1 = 64'h111; rf_rdata2 = 64'h222;
      fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset", "out_valid", 64'(out_valid), 64'd0);
      chk("reset", "out_pc", out_pc, 64'd0);
      chk("reset", "out_imm", out_imm, 64'd0);
      chk("reset", "out_opcode", 64'(out_opcode_info), 64'd0);
      chk("reset", "out_reg_wen", 64'(out_reg_wen), 64'd0);
      chk("reset", "out_rs1_data", out_rs1_data, 64'd0);
      rst = 1'b0;

      // addi x5,x0,7
      in_instr = 32'h00700293; #1;
      chk("addi", "rf_rs1", 64'(rf_rs1), 64'd0);
      chk("addi", "rf_rs2", 64'(rf_rs2), 64'd7);
      e = mk(64'h1000, 12'h020, 28'h1, 6'h0, 11'h0, 64'd7, 64'h0, 64'h222, 5'd0, 5'd7, 5'd5, 1'b1, 1'b0);
      offer("addi", 32'h00700293, 64'h1000, e);

      // add x3,x1,x2: sources 0 and 1 both hold x1, source 0 wins
      fwd_valid = 3'b011; fwd_rd = {5'd0, 5'd1, 5'd1}; fwd_data = {64'h0, 64'hBB, 64'hAA};
      e = mk(64'h1004, 12'h080, 28'h1, 6'h0, 11'h0, 64'd0, 64'hAA, 64'h222, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      offer("fwd_prio", 32'h002081B3, 64'h1004, e);

      // source 0 invalid: x1 from source 1, x2 from source 2
      fwd_valid = 3'b110; fwd_rd = {5'd2, 5'd1, 5'd1}; fwd_data = {64'hCC, 64'hBB, 64'hAA};
      e = mk(64'h1008, 12'h080, 28'h1, 6'h0, 11'h0, 64'd0, 64'hBB, 64'hCC, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      offer("fwd_older", 32'h002081B3, 64'h1008, e);

      // RAW hazard on x1 against a pending load
      fwd_valid = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd1}; fwd_pending = 3'b001;
      fwd_data = {64'h0, 64'h0, 64'hDD};
      in_instr = 32'h002081B3; in_pc = 64'h100C; in_valid = 1'b1; #1;
      chk("raw", "in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("raw", "bubble_valid", 64'(out_valid), 64'd0);
      chk("raw", "in_ready_2", 64'(in_ready), 64'd0);
      tick();
      chk("raw", "bubble_valid_2", 64'(out_valid), 64'd0);
      fwd_pending = 3'b000;
      e = mk(64'h100C, 12'h080, 28'h1, 6'h0, 11'h0, 64'd0, 64'hDD, 64'h222, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      offer("raw_release", 32'h002081B3, 64'h100C, e);

      // back-pressure: held outputs stay stable while a new instruction waits
      out_ready = 1'b0; fwd_data = {64'h0, 64'h0, 64'hEE};
      in_instr = 32'h00700293; in_pc = 64'h1010; in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("hold", "in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("hold", "out_valid", 64'(out_valid), 64'd1);
         cmp_fields("hold", held);
      end
      flush = 1'b1; out_ready = 1'b1; #1;
      chk("flush", "in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("flush", "out_valid", 64'(out_valid), 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      chk("flush", "no_capture", 64'(out_valid), 64'd0);
      $display("txn flush valid=%0b", out_valid);

      // mul x0,x1,x2
      fwd_valid = '0;
`ifdef DECODE_RV64M_EN
      e = mk(64'h2000, 12'h080, 28'h0008000, 6'h0, 11'h0, 64'd0, 64'h111, 64'h222, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
`else
      e = mk(64'h2000, 12'h080, 28'h0, 6'h0, 11'h0, 64'd0, 64'h111, 64'h222, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
`endif
      offer("mul", 32'h02208033, 64'h2000, e);

      e = mk(64'h2004, 12'h000, 28'h0, 6'h0, 11'h0, 64'd0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      offer("opc_7f", 32'h0000007F, 64'h2004, e);

      // beq x1,x2,-4
      e = mk(64'h2008, 12'h002, 28'h0, 6'b100000, 11'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h111, 64'h222,
             5'd1, 5'd2, 5'd29, 1'b0, 1'b0);
      offer("beq", 32'hFE208EE3, 64'h2008, e);

      // lui x6,0x80000
      e = mk(64'h200C, 12'h800, 28'h0, 6'h0, 11'h0, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h0,
             5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
      offer("lui", 32'h80000337, 64'h200C, e);

      // ld x7,-8(x1)
      e = mk(64'h2010, 12'h008, 28'h0, 6'h0, 11'h080, 64'hFFFF_FFFF_FFFF_FFF8, 64'h111, 64'h222,
             5'd1, 5'd24, 5'd7, 1'b1, 1'b0);
      offer("ld", 32'hFF80B383, 64'h2010, e);

      // reset while stalled drops the held instruction
      out_ready = 1'b0;
      tick();
      chk("rst_stall", "held_valid", 64'(out_valid), 64'd1);
      rst = 1'b1; #1;
      chk("rst_stall", "out_valid", 64'(out_valid), 64'd0);
      chk("rst_stall", "out_pc", out_pc, 64'd0);
      tick();
      rst = 1'b0; out_ready = 1'b1;
      tick();
      chk("rst_stall", "after_valid", 64'(out_valid), 64'd0);
      $display("txn rst_stall valid=%0b", out_valid);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV64 decode stage with its own registered D→E pipeline register and valid/ready handshake.
- Generalised over N forwarding sources, each given as a flattened bus.
- Detects RAW hazards against in-flight producers whose data is not ready yet, and stalls the fetch side.
- Supports flush from branch redirect and flags illegal instructions.
- Sits between the fetch buffer and the execute stage; the register file sits outside the block.

Parameters:
- WIDTH, 64, datapath width.
- NUM_FWD, 3, number of forwarding sources; index 0 is the youngest and has the highest priority.
- OP_SIZE, 12, opcode one-hot width.
- ALU_SIZE, 28, ALU one-hot width.
- GPR_SIZE, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  WIDTH  instruction pc.
- flush  in  1  kill the held and incoming instruction.
- rf_rs1, rf_rs2  out  GPR_SIZE  regfile read addresses; combinational from in_instr[19:15] and in_instr[24:20].
- rf_rdata1, rf_rdata2  in  WIDTH  regfile read data; write-first regfile.
- fwd_valid  in  NUM_FWD  source i will write rd.
- fwd_pending  in  NUM_FWD  source i result not yet available (e.g. load in flight).
- fwd_rd  in  NUM_FWD*GPR_SIZE  destination of source i.
- fwd_data  in  NUM_FWD*WIDTH  result of source i.
- out_valid  out  1  registered instruction valid.
- out_ready  in  1  execute accepts.
- out_pc  out  WIDTH  registered pc.
- out_opcode_info  out  OP_SIZE  one-hot class {lui,auipc,jal,jalr,alu_reg,alu_regw,alu_imm,alu_immw,load,store,branch,system}, MSB first.
- out_alu_info  out  ALU_SIZE  one-hot ALU op.
- out_branch_info  out  6  {beq,bne,blt,bge,bltu,bgeu}.
- out_ls_info  out  11  {lb,lh,lw,ld,lbu,lhu,lwu,sb,sh,sw,sd}.
- out_imm  out  WIDTH  sign-extended immediate (I/S/B/J/U; 0 for R-type).
- out_rs1_data, out_rs2_data  out  WIDTH  forwarded operands.
- out_rs1, out_rs2, out_rd  out  GPR_SIZE  register indices.
- out_reg_wen  out  1  writes rd (I/U/J/R types, legal only).
- out_illegal  out  1  unrecognised encoding.

Behaviour:
- Reset (asynchronous): every out_* register clears to 0, including out_valid.
- Operand use:
  - rs1 is used by every class except lui, auipc and jal.
  - rs2 is used by alu_reg, alu_regw, store and branch.
  - Index 0 never matches and always reads 0.
- Forwarding, per used operand:
  - Select the lowest i with fwd_valid[i] and fwd_rd[i] equal to the operand index.
  - If the selected source has fwd_pending[i]=1, a hazard exists.
  - Otherwise the selected fwd_data[i] is used.
  - If no source matches, rf_rdata is used.
- hazard = in_valid and (rs1 hazard or rs2 hazard).
- in_ready = !flush and !hazard and (!out_valid or out_ready).
- Capture: on in_valid and in_ready, all out_* load the decoded values, with out_valid=1, at the next edge. Latency is 1 cycle.
- Drain: when out_valid and out_ready and no capture, out_valid<=0. This inserts a bubble during a hazard.
- Hold: when out_valid and !out_ready, all outputs are held stable.
- Flush: flush=1 → out_valid<=0 at the next edge and nothing is captured. Flush overrides every other event in the same cycle.
- Illegal decode:
  - Any opcode outside the 12 classes, or any funct3/funct7 combination not decoded, gives out_illegal=1, out_reg_wen=0, and all-zero alu/branch/ls one-hots.
  - The instruction still flows through the stage (out_valid=1).
- Immediates: I={52{i[31]},i[31:20]}; S, B and J per the ISA; U={32{i[31]},i[31:12],12'b0}.
- Reset mid-stall drops the held instruction.

Optional Feature:
- DECODE_RV64M_EN defined: mul, mulh, mulhsu, mulhu, div, divu, rem, remu, mulw, divw, divuw, remw and remuw decode onto their out_alu_info bits.
- Undefined: those bits are tied to 0, and funct7=0000001 on alu_reg or alu_regw is illegal.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants;
  - OP_SIZE, ALU_SIZE and GPR_SIZE;
  - one-hot bit-index localparams for opcode, alu, branch and ls.
- Sub-module decode_fwd_mux, instantiated twice: priority forwarding select plus hazard flag for one operand.

Test Plan:
1. Reset asserted for 3 cycles → out_valid=0 and all outputs 0; release, offer addi x5,x0,7 (0x00700293) → next cycle out_valid=1, out_imm=7, out_rd=5, out_reg_wen=1.
2. add x3,x1,x2 with fwd_valid=3'b011, fwd_rd[0]=1 and fwd_rd[1]=1, fwd_data[0]=0xAA, fwd_data[1]=0xBB → out_rs1_data=0xAA (source 0 wins), out_rs2_data=rf_rdata2.
3. fwd_pending[0]=1 for rd=1 while offering add x3,x1,x2, out_ready=1 → in_ready=0 and out_valid drops to 0; clear pending → captured next edge.
4. out_ready=0 for 4 cycles with out_valid=1 → outputs stable and in_ready=0; flush pulsed → out_valid=0 the next cycle and the offered instruction is not captured.
5. 0x02208033 (mul x0,x1,x2) → with DECODE_RV64M_EN: mul bit set, out_illegal=0; without it: out_illegal=1, out_reg_wen=0.
6. Opcode 0x7F and beq with imm=-4 → out_illegal=1 for the 0x7F word; for the beq, out_imm=0xFFFF_FFFF_FFFF_FFFC and branch_info=6'b100000.
